// File: rtl/camera_frame_writer.sv
// rtl/camera_frame_writer.sv - camera raster to 3:4 decimated frame buffer write strobes
`timescale 1ns/1ps

module camera_frame_writer #(
  parameter int SRC_WIDTH   = 320,
  parameter int SRC_HEIGHT  = 240,
  parameter int DST_WIDTH   = 240,
  parameter int DST_HEIGHT  = 180,
  parameter int PIXEL_WIDTH = 16,
  parameter int ADDR_WIDTH  = 17
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   frame_start_in,
  input  logic                   pixel_valid_in,
  input  logic [PIXEL_WIDTH-1:0] pixel_data_in,
  output logic [ADDR_WIDTH-1:0]  waddr_out,
  output logic [PIXEL_WIDTH-1:0] wdata_out,
  output logic                   we_out,
  output logic                   frame_done_out,
  output logic                   short_frame_out,
  output logic                   overflow_out
);

  // Counter widths; at least 2 bits so the modulo-4 drop test is always legal
  localparam int XW = (SRC_WIDTH  > 4) ? $clog2(SRC_WIDTH)  : 2;
  localparam int YW = (SRC_HEIGHT > 4) ? $clog2(SRC_HEIGHT) : 2;

  localparam logic [XW-1:0]         X_LAST    = XW'(SRC_WIDTH - 1);
  localparam logic [YW-1:0]         Y_LAST    = YW'(SRC_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DST_WIDTH * DST_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state;
  logic [XW-1:0]           src_x;
  logic [YW-1:0]           src_y;
  logic [ADDR_WIDTH-1:0]   wr_addr;

  logic [XW-1:0]           cur_x;
  logic [YW-1:0]           cur_y;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    capture;
  logic                    keep;
  logic                    last_pixel;

  // Position of the pixel on the input this cycle; a frame start makes it pixel (0,0)
  always_comb begin
    cur_x      = frame_start_in ? '0 : src_x;
    cur_y      = frame_start_in ? '0 : src_y;
    cur_addr   = frame_start_in ? '0 : wr_addr;
    capture    = pixel_valid_in && (frame_start_in || (state == ACTIVE));
    keep       = capture && (cur_x[1:0] != 2'd3) && (cur_y[1:0] != 2'd3);
    last_pixel = (cur_x == X_LAST) && (cur_y == Y_LAST);
  end

  // Frame FSM, raster counters and registered write strobe
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      src_x           <= '0;
      src_y           <= '0;
      wr_addr         <= '0;
      waddr_out       <= '0;
      wdata_out       <= '0;
      we_out          <= 1'b0;
      frame_done_out  <= 1'b0;
      short_frame_out <= 1'b0;
      overflow_out    <= 1'b0;
    end else begin
      we_out          <= 1'b0;
      frame_done_out  <= 1'b0;
      short_frame_out <= 1'b0;

      // A new frame restarts everything; the pixel handling below may refine counters
      if (frame_start_in) begin
        state           <= ACTIVE;
        short_frame_out <= (state == ACTIVE);
        overflow_out    <= 1'b0;
        src_x           <= '0;
        src_y           <= '0;
        wr_addr         <= '0;
      end else if ((state == DONE) && pixel_valid_in) begin
        overflow_out    <= 1'b1;
      end

      // Kept pixel: present it to the buffer and step the running address
      if (keep) begin
        we_out    <= 1'b1;
        waddr_out <= cur_addr;
        wdata_out <= pixel_data_in;
        if (cur_addr != ADDR_LAST) begin
          wr_addr <= cur_addr + ADDR_WIDTH'(1);
        end
      end

      // Every accepted pixel, kept or dropped, advances the raster position
      if (capture) begin
        if (cur_x == X_LAST) begin
          src_x <= '0;
          src_y <= (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
        end else begin
          src_x <= cur_x + XW'(1);
          src_y <= cur_y;
        end
        if (last_pixel) begin
          state          <= DONE;
          frame_done_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_writer.sv
// tb/tb_camera_frame_writer.sv - self-checking bench for camera_frame_writer
`timescale 1ns/1ps

module tb_camera_frame_writer;

  localparam int SW = 32;
  localparam int SH = 24;
  localparam int DW = 24;
  localparam int DH = 18;
  localparam int PW = 16;
  localparam int AW = 17;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          frame_start_in;
  logic          pixel_valid_in;
  logic [PW-1:0] pixel_data_in;
  logic [AW-1:0] waddr_out;
  logic [PW-1:0] wdata_out;
  logic          we_out;
  logic          frame_done_out;
  logic          short_frame_out;
  logic          overflow_out;

  always #5 clk_in = ~clk_in;

  camera_frame_writer #(
    .SRC_WIDTH  (SW),
    .SRC_HEIGHT (SH),
    .DST_WIDTH  (DW),
    .DST_HEIGHT (DH),
    .PIXEL_WIDTH(PW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .frame_start_in (frame_start_in),
    .pixel_valid_in (pixel_valid_in),
    .pixel_data_in  (pixel_data_in),
    .waddr_out      (waddr_out),
    .wdata_out      (wdata_out),
    .we_out         (we_out),
    .frame_done_out (frame_done_out),
    .short_frame_out(short_frame_out),
    .overflow_out   (overflow_out)
  );

  typedef struct {
    logic          fs;
    logic          pv;
    logic [PW-1:0] data;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [PW-1:0] d;
  } wr_t;

  vec_t vecs[9];
  wr_t  exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int n_done   = 0;
  int n_short  = 0;

  // reference model: 0 idle, 1 active, 2 done
  int   m_state = 0;
  int   m_x = 0;
  int   m_y = 0;
  logic m_ovf = 1'b0;
  logic e_done = 1'b0;
  logic e_short = 1'b0;

  logic          last_we;
  logic [AW-1:0] last_addr;
  logic [PW-1:0] last_data;
  logic [AW-1:0] last_wr_addr;
  logic [AW-1:0] first_wr_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input logic fs, input logic pv, input logic [PW-1:0] d);
    wr_t w;
    e_done  = 1'b0;
    e_short = 1'b0;
    if (fs) begin
      e_short = (m_state == 1);
      m_state = 1;
      m_x     = 0;
      m_y     = 0;
      m_ovf   = 1'b0;
    end
    if (pv) begin
      if (m_state == 1) begin
        if ((m_x % 4 != 3) && (m_y % 4 != 3)) begin
          w.a = AW'((m_y - m_y / 4) * DW + (m_x - m_x / 4));
          w.d = d;
          exp_q.push_back(w);
        end
        if (m_x == SW - 1 && m_y == SH - 1) begin
          m_state = 2;
          e_done  = 1'b1;
        end
        if (m_x == SW - 1) begin
          m_x = 0;
          m_y++;
        end else begin
          m_x++;
        end
      end else if (m_state == 2) begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input logic fs, input logic pv, input logic [PW-1:0] d);
    wr_t w;
    @(negedge clk_in);
    frame_start_in = fs;
    pixel_valid_in = pv;
    pixel_data_in  = d;
    model(fs, pv, d);
    @(posedge clk_in);
    #1;
    last_we   = we_out;
    last_addr = waddr_out;
    last_data = wdata_out;
    if (we_out) begin
      n_writes++;
      if (n_writes == 1) first_wr_addr = waddr_out;
      last_wr_addr = waddr_out;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", waddr_out, wdata_out);
      end else begin
        w = exp_q.pop_front();
        chk("waddr", waddr_out, w.a);
        chk("wdata", wdata_out, w.d);
      end
    end else if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_write: got we 0 expected write addr %0h", exp_q[0].a);
      exp_q.delete();
    end
    chk("frame_done", frame_done_out, e_done);
    chk("short_frame", short_frame_out, e_short);
    chk("overflow", overflow_out, m_ovf);
    if (frame_done_out) n_done++;
    if (short_frame_out) n_short++;
  endtask

  task automatic run_frame(input bit gaps);
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < SW * SH; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        int g;
        g = $urandom_range(1, 4);
        for (int k = 0; k < g; k++) step(1'b0, 1'b0, PW'($urandom));
      end
      step(1'b0, 1'b1, PW'(i));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_we"}, we_out, 0);
    chk({tag, "_waddr"}, waddr_out, 0);
    chk({tag, "_wdata"}, wdata_out, 0);
    chk({tag, "_done"}, frame_done_out, 0);
    chk({tag, "_short"}, short_frame_out, 0);
    chk({tag, "_overflow"}, overflow_out, 0);
  endtask

  initial begin
    int w0;
    int wr_before;

    // row 0, src_x 0..7 after a frame start; data equals the source index
    vecs[0] = '{1'b1, 1'b0, 16'd0, 1'b0, 17'd0};
    vecs[1] = '{1'b0, 1'b1, 16'd0, 1'b1, 17'd0};
    vecs[2] = '{1'b0, 1'b1, 16'd1, 1'b1, 17'd1};
    vecs[3] = '{1'b0, 1'b1, 16'd2, 1'b1, 17'd2};
    vecs[4] = '{1'b0, 1'b1, 16'd3, 1'b0, 17'd0};
    vecs[5] = '{1'b0, 1'b1, 16'd4, 1'b1, 17'd3};
    vecs[6] = '{1'b0, 1'b1, 16'd5, 1'b1, 17'd4};
    vecs[7] = '{1'b0, 1'b1, 16'd6, 1'b1, 17'd5};
    vecs[8] = '{1'b0, 1'b1, 16'd7, 1'b0, 17'd0};

    rst_n_in       = 1'b0;
    frame_start_in = 1'b0;
    pixel_valid_in = 1'b0;
    pixel_data_in  = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // pixels before any frame start are ignored
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, PW'(i + 500));
    chk("presync_writes", n_writes, 0);

    // contiguous full frame, starting with the decimation table
    n_writes = 0;
    n_done   = 0;
    foreach (vecs[i]) begin
      step(vecs[i].fs, vecs[i].pv, vecs[i].data);
      chk("vec_we", last_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk("vec_addr", last_addr, vecs[i].exp_addr);
        chk("vec_data", last_data, vecs[i].data);
      end
    end
    w0 = 0;
    for (int i = 8; i < SW * SH; i++) begin
      if (i == 3 * SW) w0 = n_writes;
      step(1'b0, 1'b1, PW'(i));
      if (i == 4 * SW - 1) chk("row3_writes", n_writes - w0, 0);
      if (i == 4 * SW) begin
        chk("row4_we", last_we, 1);
        chk("row4_addr", last_addr, 3 * DW);
      end
    end
    chk("full_writes", n_writes, DW * DH);
    chk("full_done_count", n_done, 1);
    chk("full_last_addr", last_wr_addr, DW * DH - 1);
    chk("full_overflow", overflow_out, 0);

    // extra pixels after a complete frame set a sticky overflow
    wr_before = n_writes;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, PW'(i));
    chk("ovf_set", overflow_out, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    chk("ovf_held", overflow_out, 1);
    chk("ovf_no_writes", n_writes - wr_before, 0);

    // frame with random valid gaps; frame start clears overflow
    n_writes = 0;
    n_done   = 0;
    run_frame(1'b1);
    chk("gap_writes", n_writes, DW * DH);
    chk("gap_done_count", n_done, 1);
    chk("gap_first_addr", first_wr_addr, 0);
    chk("gap_last_addr", last_wr_addr, DW * DH - 1);
    step(1'b1, 1'b0, '0);
    chk("ovf_cleared", overflow_out, 0);

    // short frame: restart with a pixel in the same cycle as frame start
    n_short = 0;
    n_done  = 0;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, PW'(i));
    step(1'b1, 1'b1, 16'hBEEF);
    chk("short_same_we", last_we, 1);
    chk("short_same_addr", last_addr, 0);
    chk("short_same_data", last_data, 16'hBEEF);
    step(1'b0, 1'b0, '0);
    chk("short_count", n_short, 1);
    chk("short_no_done", n_done, 0);

    // async reset between edges right after a kept write
    step(1'b0, 1'b1, 16'h1234);
    chk("pre_reset_we", last_we, 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    m_state = 0;
    m_ovf   = 1'b0;
    exp_q.delete();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    wr_before = n_writes;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, PW'(i));
    chk("post_reset_ignored", n_writes - wr_before, 0);
    n_writes = 0;
    n_done   = 0;
    run_frame(1'b0);
    chk("post_reset_first_addr", first_wr_addr, 0);
    chk("post_reset_writes", n_writes, DW * DH);
    chk("post_reset_done", n_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
